// File: rtl/binary_to_bcd_pkg.sv
// binary_to_bcd_pkg: shared FSM state encoding and double-dabble constants
package binary_to_bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd4;
endpackage

// File: rtl/binary_to_bcd_hs_if.sv
// binary_to_bcd_hs_if: request/result handshake bundle for the converter
interface binary_to_bcd_hs_if #(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5
);
  logic [INPUT_WIDTH-1:0]      i_Binary;
  logic                        i_Valid;
  logic                        o_Ready;
  logic [DECIMAL_DIGITS*4-1:0] o_BCD;
  logic                        o_Sign;
  logic [DECIMAL_DIGITS-1:0]   o_Blank;
  logic                        o_Overflow;
  logic                        o_Valid;
  logic                        i_Ready;
  modport master (output i_Binary, i_Valid, i_Ready, input o_Ready, o_BCD, o_Sign, o_Blank, o_Overflow, o_Valid);
  modport slave (input i_Binary, i_Valid, i_Ready, output o_Ready, o_BCD, o_Sign, o_Blank, o_Overflow, o_Valid);
endinterface

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust
  import binary_to_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  always_comb o_digit = (i_digit > ADD3_THRESHOLD) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/binary_to_bcd_hs.sv
// binary_to_bcd_hs: bit-serial double-dabble binary to BCD converter with valid/ready handshake
module binary_to_bcd_hs
  import binary_to_bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5,
  parameter int SIGNED_MODE    = 0
) (
  input logic               i_Clock,
  input logic               i_Reset_n,
  binary_to_bcd_hs_if.slave bus
);
  localparam int CW = $clog2(INPUT_WIDTH + 1);
  localparam int BW = DECIMAL_DIGITS * 4;
  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]          bcd_q, bcd_d, adj;
  logic                   sign_q, sign_d, ovf_q, ovf_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DECIMAL_DIGITS-1:0] blank;
  for (genvar i = 0; i < DECIMAL_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (.i_digit(bcd_q[4*i +: 4]), .o_digit(adj[4*i +: 4]));
  end
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.i_Valid) begin
        sign_d  = (SIGNED_MODE != 0) && bus.i_Binary[INPUT_WIDTH-1];
        mag_d   = sign_d ? -bus.i_Binary : bus.i_Binary;
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        // the top digit's carry-out is the only bit that can be lost
        bcd_d   = {adj[BW-2:0], mag_q[INPUT_WIDTH-1]};
        ovf_d   = ovf_q | adj[BW-1];
        mag_d   = mag_q << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(INPUT_WIDTH - 1)) ? DONE : CONVERT;
      end
      DONE: state_d = bus.i_Ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int i = DECIMAL_DIGITS - 1; i > 0; i--) begin
      z        = z & (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = z;
    end
  end
  assign bus.o_Ready    = (state_q == IDLE);
  assign bus.o_Valid    = (state_q == DONE);
  assign bus.o_BCD      = bcd_q;
  assign bus.o_Sign     = sign_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Blank    = blank;
endmodule

// File: tb/tb_binary_to_bcd_hs.sv
// tb_binary_to_bcd_hs: three converter configurations driven in lockstep against hand-computed vectors
module tb_binary_to_bcd_hs;
  logic clk, rst_n, vin, rdy;
  logic [15:0] bin;
  int checks = 0;
  int errors = 0;
  binary_to_bcd_hs_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) b0 ();
  binary_to_bcd_hs_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) b1 ();
  binary_to_bcd_hs_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) b2 ();
  binary_to_bcd_hs #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED_MODE(0)) u0 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b0));
  binary_to_bcd_hs #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4), .SIGNED_MODE(0)) u1 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b1));
  binary_to_bcd_hs #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED_MODE(1)) u2 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(b2));
  assign b0.i_Binary = bin;
  assign b1.i_Binary = bin;
  assign b2.i_Binary = bin;
  assign b0.i_Valid  = vin;
  assign b1.i_Valid  = vin;
  assign b2.i_Valid  = vin;
  assign b0.i_Ready  = rdy;
  assign b1.i_Ready  = rdy;
  assign b2.i_Ready  = rdy;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bin;
    logic [19:0] bcd0;
    logic [4:0]  blk0;
    logic [15:0] bcd1;
    logic [3:0]  blk1;
    logic        ovf1;
    logic        sgn2;
    logic [19:0] bcd2;
    logic [4:0]  blk2;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] v);
    @(negedge clk);
    bin = v;
    vin = 1'b1;
    chk("ready_before_accept", 64'(b0.o_Ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
  endtask

  // lat counts the accept edge as 1 and stops at the edge that raises o_Valid
  task automatic wait_done(output int lat);
    lat = 1;
    while (!b0.o_Valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake;
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy = 1'b0;
    chk("valid_fall", 64'(b0.o_Valid), 64'(0));
    chk("ready_back", 64'(b0.o_Ready), 64'(1));
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, " bcd0"}, 64'(b0.o_BCD), 64'(v.bcd0));
    chk({tag, " blk0"}, 64'(b0.o_Blank), 64'(v.blk0));
    chk({tag, " ovf0"}, 64'(b0.o_Overflow), 64'(0));
    chk({tag, " sgn0"}, 64'(b0.o_Sign), 64'(0));
    chk({tag, " bcd1"}, 64'(b1.o_BCD), 64'(v.bcd1));
    chk({tag, " blk1"}, 64'(b1.o_Blank), 64'(v.blk1));
    chk({tag, " ovf1"}, 64'(b1.o_Overflow), 64'(v.ovf1));
    chk({tag, " sgn1"}, 64'(b1.o_Sign), 64'(0));
    chk({tag, " bcd2"}, 64'(b2.o_BCD), 64'(v.bcd2));
    chk({tag, " blk2"}, 64'(b2.o_Blank), 64'(v.blk2));
    chk({tag, " sgn2"}, 64'(b2.o_Sign), 64'(v.sgn2));
    chk({tag, " valid_sync"}, 64'({b1.o_Valid, b2.o_Valid}), 64'(2'b11));
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    string tag;
    tag = $sformatf("vec_%04h", v.bin);
    start(v.bin);
    wait_done(lat);
    chk({tag, " latency"}, 64'(lat), 64'(17));
    check_result(tag, v);
    handshake();
    chk({tag, " hold_idle"}, 64'(b0.o_BCD), 64'(v.bcd0));
  endtask

  initial begin
    int lat, n, seen;
    vt[0] = '{16'hFFFF, 20'h65535, 5'b00000, 16'h5535, 4'b0000, 1'b1, 1'b1, 20'h00001, 5'b11110};
    vt[1] = '{16'h0000, 20'h00000, 5'b11110, 16'h0000, 4'b1110, 1'b0, 1'b0, 20'h00000, 5'b11110};
    vt[2] = '{16'h0009, 20'h00009, 5'b11110, 16'h0009, 4'b1110, 1'b0, 1'b0, 20'h00009, 5'b11110};
    vt[3] = '{16'h270F, 20'h09999, 5'b10000, 16'h9999, 4'b0000, 1'b0, 1'b0, 20'h09999, 5'b10000};
    vt[4] = '{16'h8000, 20'h32768, 5'b00000, 16'h2768, 4'b0000, 1'b1, 1'b1, 20'h32768, 5'b00000};
    vt[5] = '{16'h1234, 20'h04660, 5'b10000, 16'h4660, 4'b0000, 1'b0, 1'b0, 20'h04660, 5'b10000};
    vt[6] = '{16'h0064, 20'h00100, 5'b11000, 16'h0100, 4'b1000, 1'b0, 1'b0, 20'h00100, 5'b11000};
    vt[7] = '{16'hFF9C, 20'h65436, 5'b00000, 16'h5436, 4'b0000, 1'b1, 1'b1, 20'h00100, 5'b11000};
    rst_n = 1'b0;
    vin = 1'b0;
    rdy = 1'b0;
    bin = '0;
    #12;
    chk("reset ready", 64'(b0.o_Ready), 64'(1));
    chk("reset valid", 64'(b0.o_Valid), 64'(0));
    chk("reset bcd", 64'(b0.o_BCD), 64'(0));
    chk("reset blank", 64'(b0.o_Blank), 64'(5'b11110));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(vt[i]);
    // overflow must clear on the next accept
    run_vec(vt[0]);
    run_vec(vt[3]);

    // held result while downstream stalls; stray request mid-conversion is ignored
    start(16'h1234);
    repeat (3) @(negedge clk);
    bin = 16'h0001;
    vin = 1'b1;
    chk("stall ready_in_convert", 64'(b0.o_Ready), 64'(0));
    @(negedge clk);
    vin = 1'b0;
    wait_done(lat);
    chk("stall reached_done", 64'(b0.o_Valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall hold_%0d bcd", i), 64'(b0.o_BCD), 64'(20'h04660));
      chk($sformatf("stall hold_%0d valid", i), 64'({b0.o_Valid, b0.o_Ready}), 64'(2'b10));
    end
    handshake();
    repeat (3) @(negedge clk);
    chk("stall pulse_not_accepted valid", 64'(b0.o_Valid), 64'(0));
    chk("stall pulse_not_accepted bcd", 64'(b0.o_BCD), 64'(20'h04660));

    // back-to-back throughput with request and ready held high
    @(negedge clk);
    bin = 16'h0064;
    vin = 1'b1;
    rdy = 1'b1;
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b0.o_Ready) break;
      @(posedge clk);
      n++;
    end
    chk("period accept_to_accept", 64'(n + 1), 64'(18));
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    rdy = 1'b0;
    wait_done(lat);
    chk("period second_latency", 64'(lat), 64'(17));
    chk("period second_bcd", 64'(b0.o_BCD), 64'(20'h00100));
    handshake();

    // asynchronous reset in the eighth conversion cycle
    start(16'hFFFF);
    repeat (7) @(negedge clk);
    #2;
    chk("mid_reset pre sign", 64'(b2.o_Sign), 64'(1));
    chk("mid_reset pre ready", 64'(b0.o_Ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_reset bcd0", 64'(b0.o_BCD), 64'(0));
    chk("mid_reset sign2", 64'(b2.o_Sign), 64'(0));
    chk("mid_reset ovf1", 64'(b1.o_Overflow), 64'(0));
    chk("mid_reset valid", 64'({b0.o_Valid, b1.o_Valid, b2.o_Valid}), 64'(0));
    chk("mid_reset ready", 64'({b0.o_Ready, b1.o_Ready, b2.o_Ready}), 64'(3'b111));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen += int'(b0.o_Valid);
    end
    chk("mid_reset discarded", 64'(seen), 64'(0));
    run_vec(vt[3]);

    // asynchronous reset while holding a result
    start(16'h0009);
    wait_done(lat);
    chk("done_reset pre valid", 64'(b0.o_Valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("done_reset valid", 64'(b0.o_Valid), 64'(0));
    chk("done_reset bcd", 64'(b0.o_BCD), 64'(0));
    chk("done_reset ready", 64'(b0.o_Ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
